// File: rtl/router_lane_out_stage_pkg.sv
// Shared NoC constants for the router output stage: flit format and VC id field.
package noc_params;

    localparam int FLIT_W = 64;  // flit width in bits
    localparam int VC_NUM = 2;   // virtual channels per link
    localparam int VC_LSB = 0;   // bit offset of the VC id inside a flit

    // Width of the VC id field; one bit minimum even for a single VC.
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VC_W = vc_width(VC_NUM);

endpackage

// File: rtl/router_lane_out_stage_fifo.sv
// Per-lane flit FIFO: storage, pointers, occupancy and the head flit.
// A push is accepted only against the registered count, so a same-cycle pop
// never makes room for a push into a full FIFO.
module lane_fifo #(
    parameter int FLIT_W = noc_params::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [FLIT_W-1:0] o_head,
    output logic              o_ready,
    output logic              o_not_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_ready     = (r_count != CW'(DEPTH));
    assign o_not_empty = (r_count != '0);
    assign o_head      = r_mem[r_rd_ptr];
    assign w_push      = i_valid && o_ready;
    assign w_pop       = i_pop && o_not_empty;

    // Storage write; the pointers and count fully define which entries are valid.
    // NOTE: storage is deliberately not reset -- stale entries are never read, and
    // leaving the array out of reset lets it map onto plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_lane_out_stage.sv
// Router output stage: LANES independent lanes, each a FIFO whose head departs
// only when the downstream on/off bit for the head flit's VC (registered once) is set.
// Also keeps sticky overflow flags and saturating head-of-line stall counters.
module router_lane_out_stage
    import noc_params::*;
#(
    parameter int LANES  = 10,
    parameter int FLIT_W = noc_params::FLIT_W,
    parameter int VC_NUM = noc_params::VC_NUM,
    parameter int VC_LSB = noc_params::VC_LSB,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0][FLIT_W-1:0]  flit_i,
    input  logic [LANES-1:0]              valid_i,
    output logic [LANES-1:0]              ready_o,
    input  logic [LANES-1:0][VC_NUM-1:0]  on_off_i,
    output logic [LANES-1:0][FLIT_W-1:0]  data_o,
    output logic [LANES-1:0]              valid_o,
    output logic [LANES-1:0]              overflow_o,
    output logic [LANES-1:0][CNT_W-1:0]   stall_cnt_o
);

    localparam int VC_W = vc_width(VC_NUM);

    logic [LANES-1:0][VC_NUM-1:0] r_on_off_q;

    // One register stage on the downstream flow-control bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_on_off_q <= '0;
        else      r_on_off_q <= on_off_i;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [FLIT_W-1:0] w_head;
        logic [VC_W-1:0]   w_head_vc;
        logic              w_ready;
        logic              w_not_empty;
        logic              w_vc_on;
        logic              w_pop;
        logic [FLIT_W-1:0] r_data;
        logic              r_valid;
        logic              r_overflow;
        logic [CNT_W-1:0]  r_stall;

        lane_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (valid_i[g]),
            .i_data      (flit_i[g]),
            .i_pop       (w_pop),
            .o_head      (w_head),
            .o_ready     (w_ready),
            .o_not_empty (w_not_empty)
        );

        assign w_head_vc = w_head[VC_LSB +: VC_W];

        // Head VC permission; an out-of-range VC id is treated as off so the flit stalls.
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            w_vc_on = 1'b0;
            if (int'(w_head_vc) < VC_NUM) w_vc_on = r_on_off_q[g][w_head_vc];
        end

        assign w_pop = w_not_empty && w_vc_on;

        // Link output register: data holds its last value when nothing departs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_pop;
                if (w_pop) r_data <= w_head;
            end
        end

        // Debug: sticky overflow on a push into a full FIFO, saturating head-blocked counter.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_overflow <= 1'b0;
                r_stall    <= '0;
            end else begin
                if (valid_i[g] && !w_ready) r_overflow <= 1'b1;
                if (w_not_empty && !w_vc_on && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
            end
        end

        assign ready_o[g]     = w_ready;
        assign data_o[g]      = r_data;
        assign valid_o[g]     = r_valid;
        assign overflow_o[g]  = r_overflow;
        assign stall_cnt_o[g] = r_stall;
    end

endmodule

// File: tb/tb_router_lane_out_stage.sv
// Directed testbench for router_lane_out_stage: latency, full/overflow, per-VC gating,
// steady push/pop, lane isolation, mid-traffic reset and stall counter saturation.
module tb_router_lane_out_stage;

    localparam int LANES = 10;
    localparam int FW    = 64;
    localparam int VCN   = 2;
    localparam int CW    = 16;
    localparam logic [LANES-1:0] ALL_ONES = '1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [LANES-1:0][FW-1:0]  flit_i;
    logic [LANES-1:0]          valid_i;
    logic [LANES-1:0]          ready_o;
    logic [LANES-1:0][VCN-1:0] on_off_i;
    logic [LANES-1:0][FW-1:0]  data_o;
    logic [LANES-1:0]          valid_o;
    logic [LANES-1:0]          overflow_o;
    logic [LANES-1:0][CW-1:0]  stall_cnt_o;

    // Single-lane instance with a narrow counter for the saturation check.
    logic [0:0][FW-1:0]  s_flit;
    logic [0:0]          s_valid;
    logic [0:0]          s_ready;
    logic [0:0][VCN-1:0] s_on_off;
    logic [0:0][FW-1:0]  s_data;
    logic [0:0]          s_valid_o;
    logic [0:0]          s_overflow;
    logic [0:0][3:0]     s_stall;

    router_lane_out_stage #(.LANES(LANES), .FLIT_W(FW), .VC_NUM(VCN), .VC_LSB(0), .DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o),
        .on_off_i(on_off_i), .data_o(data_o), .valid_o(valid_o),
        .overflow_o(overflow_o), .stall_cnt_o(stall_cnt_o)
    );

    router_lane_out_stage #(.LANES(1), .FLIT_W(FW), .VC_NUM(VCN), .VC_LSB(0), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flit_i(s_flit), .valid_i(s_valid), .ready_o(s_ready),
        .on_off_i(s_on_off), .data_o(s_data), .valid_o(s_valid_o),
        .overflow_o(s_overflow), .stall_cnt_o(s_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fl(input logic [7:0] lane, input int idx);
        return {lane, 40'h0, 8'(idx), 8'h00};  // VC bit (LSB) is 0 -> VC0
    endfunction

    localparam logic [63:0] LAT_FLIT = 64'hA5A5_0000_1234_5670;
    localparam logic [63:0] VC1_FLIT = 64'hB1B1_0000_0000_0001;
    localparam logic [63:0] VC0_FLIT = 64'hB0B0_0000_0000_0002;

    initial begin
        flit_i   = '0;
        valid_i  = '0;
        on_off_i = '0;
        s_flit   = '0;
        s_valid  = '0;
        s_on_off = '0;

        // ---------------- reset state ----------------
        rst = 1'b0;
        tick();
        tick();
        check("rst_valid_o",    64'(valid_o), 64'h0);
        check("rst_ready_o",    64'(ready_o), 64'(ALL_ONES));
        check("rst_overflow_o", 64'(overflow_o), 64'h0);
        check("rst_stall0",     64'(stall_cnt_o[0]), 64'h0);
        check("rst_data0",      data_o[0], 64'h0);
        rst = 1'b1;
        on_off_i = '1;
        tick();

        // ---------------- latency: push at t, valid at t+2 ----------------
        flit_i[0]  = LAT_FLIT;
        valid_i[0] = 1'b1;
        tick();
        valid_i[0] = 1'b0;
        check("lat_t1_valid", 64'(valid_o[0]), 64'h0);
        tick();
        check("lat_t2_valid", 64'(valid_o[0]), 64'h1);
        check("lat_t2_data",  data_o[0], LAT_FLIT);
        tick();
        check("lat_t3_valid", 64'(valid_o[0]), 64'h0);
        check("lat_t3_hold",  data_o[0], LAT_FLIT);

        // ---------------- full / overflow on lane 3 ----------------
        on_off_i[3] = 2'b00;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("full_ready_pre", 64'(ready_o[3]), (k < 4) ? 64'h1 : 64'h0);
            flit_i[3]  = fl(8'h33, k);
            valid_i[3] = 1'b1;
            tick();
            check("full_ovf", 64'(overflow_o[3]), (k == 4) ? 64'h1 : 64'h0);
        end
        valid_i[3] = 1'b0;
        check("full_ready_after", 64'(ready_o[3]), 64'h0);
        check("full_no_depart",   64'(valid_o[3]), 64'h0);
        on_off_i[3] = 2'b11;
        tick();
        check("full_sample_stage", 64'(valid_o[3]), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_valid", 64'(valid_o[3]), 64'h1);
            check("drain_data",  data_o[3], fl(8'h33, k));
        end
        tick();
        check("drain_end_valid", 64'(valid_o[3]), 64'h0);
        check("drain_ready",     64'(ready_o[3]), 64'h1);
        check("drain_ovf_sticky", 64'(overflow_o[3]), 64'h1);

        // ---------------- per-VC gating + stall count on lane 1 ----------------
        on_off_i[1] = 2'b01;  // VC0 on, VC1 off
        flit_i[1]   = VC1_FLIT;
        valid_i[1]  = 1'b1;
        tick();
        flit_i[1]   = VC0_FLIT;
        tick();
        valid_i[1]  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("vc_blocked", 64'(valid_o[1]), 64'h0);
        end
        check("vc_stall10", 64'(stall_cnt_o[1]), 64'd10);
        on_off_i[1] = 2'b11;
        tick();
        check("vc_sample_stage", 64'(valid_o[1]), 64'h0);
        tick();
        check("vc_head_valid", 64'(valid_o[1]), 64'h1);
        check("vc_head_data",  data_o[1], VC1_FLIT);
        tick();
        check("vc_next_valid", 64'(valid_o[1]), 64'h1);
        check("vc_next_data",  data_o[1], VC0_FLIT);
        tick();
        check("vc_end_valid", 64'(valid_o[1]), 64'h0);
        check("vc_stall_final", 64'(stall_cnt_o[1]), 64'd11);

        // ---------------- steady push/pop at count=2 on lane 4 ----------------
        on_off_i[4] = 2'b00;
        tick();
        flit_i[4]   = fl(8'h44, 0);
        valid_i[4]  = 1'b1;
        tick();
        flit_i[4]   = fl(8'h44, 1);
        on_off_i[4] = 2'b11;
        tick();
        check("pp_ready_at2", 64'(ready_o[4]), 64'h1);
        for (int k = 2; k < 20; k++) begin
            flit_i[4] = fl(8'h44, k);
            tick();
            check("pp_valid", 64'(valid_o[4]), 64'h1);
            check("pp_data",  data_o[4], fl(8'h44, k - 2));
            check("pp_ready", 64'(ready_o[4]), 64'h1);
        end
        valid_i[4] = 1'b0;
        for (int k = 18; k < 20; k++) begin
            tick();
            check("pp_tail_data", data_o[4], fl(8'h44, k));
        end
        tick();
        check("pp_end_valid", 64'(valid_o[4]), 64'h0);

        // ---------------- lane isolation: lane 2 blocked, lanes 0/1 streaming ----------------
        on_off_i[2] = 2'b00;
        tick();
        flit_i[2]  = fl(8'h22, 0);
        valid_i[2] = 1'b1;
        valid_i[0] = 1'b1;
        valid_i[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            flit_i[0] = fl(8'h10, k);
            flit_i[1] = fl(8'h11, k);
            tick();
            valid_i[2] = 1'b0;
            if (k >= 1) begin
                check("iso_l0_data", data_o[0], fl(8'h10, k - 1));
                check("iso_l1_data", data_o[1], fl(8'h11, k - 1));
                check("iso_l01_valid", 64'(valid_o[1:0]), 64'h3);
                check("iso_l2_valid", 64'(valid_o[2]), 64'h0);
            end
        end
        valid_i[0] = 1'b0;
        valid_i[1] = 1'b0;
        tick();
        check("iso_l0_last", data_o[0], fl(8'h10, 7));
        check("iso_l2_ready", 64'(ready_o[2]), 64'h1);
        check("iso_l2_ovf",   64'(overflow_o[2]), 64'h0);
        check("iso_l2_stall", 64'(stall_cnt_o[2]), 64'd8);
        check("iso_l3_ovf",   64'(overflow_o[3]), 64'h1);

        // ---------------- mid-traffic reset with 3 flits queued on lane 5 ----------------
        on_off_i[5] = 2'b00;
        tick();
        valid_i[5] = 1'b1;
        valid_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flit_i[5] = fl(8'h55, k);
            flit_i[0] = fl(8'h50, k);
            tick();
        end
        check("pre_rst_l0_valid", 64'(valid_o[0]), 64'h1);
        check("pre_rst_l5_stall", 64'(stall_cnt_o[5]), 64'd2);
        valid_i = '0;
        rst = 1'b0;
        #1;
        check("arst_valid_o", 64'(valid_o), 64'h0);
        check("arst_ready_o", 64'(ready_o), 64'(ALL_ONES));
        check("arst_ovf",     64'(overflow_o), 64'h0);
        check("arst_stall5",  64'(stall_cnt_o[5]), 64'h0);
        check("arst_stall2",  64'(stall_cnt_o[2]), 64'h0);
        check("arst_data0",   data_o[0], 64'h0);
        tick();
        tick();
        rst = 1'b1;
        on_off_i = '1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_no_flit", 64'(valid_o), 64'h0);
        end

        // ---------------- stall counter saturation (CNT_W=4) ----------------
        s_on_off  = '0;
        s_flit[0] = 64'h0000_0000_0000_0770;
        s_valid   = 1'b1;
        tick();
        s_valid   = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("sat_stall5", 64'(s_stall[0]), 64'd5);
        for (int k = 0; k < 15; k++) tick();
        check("sat_stall15", 64'(s_stall[0]), 64'd15);
        for (int k = 0; k < 5; k++) tick();
        check("sat_hold15", 64'(s_stall[0]), 64'd15);
        check("sat_no_depart", 64'(s_valid_o[0]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
